// File: rtl/lane_pack_serializer.sv
// Collects one frame of per-lane a/b bits, packs it as {b, a} and streams it
// out LSB-first in BEAT_W-bit beats over a valid/ready handshake.
module lane_pack_serializer #(
    parameter int LANES  = 8,
    parameter int BEAT_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [LANES-1:0]  i_a,
    input  logic [LANES-1:0]  i_b,
    output logic              o_ready,
    output logic              o_valid,
    output logic [BEAT_W-1:0] o_data,
    output logic              o_last,
    input  logic              i_ready,
    output logic [7:0]        o_drop_cnt
);

    // state  | meaning
    // S_IDLE | waiting for a frame, o_ready high
    // S_SEND | streaming beats of the captured word, new frames are dropped

    localparam int WORD_W  = 2 * LANES;
    localparam int BEATS   = WORD_W / BEAT_W;
    localparam int BEAT_CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_CW-1:0] LAST_BEAT = BEAT_CW'(BEATS - 1);

    generate
        if ((WORD_W % BEAT_W) != 0) begin : g_bad_cfg
            $error("lane_pack_serializer: 2*LANES must be a multiple of BEAT_W");
        end
    endgenerate

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t              r_state;
    logic [WORD_W-1:0]   r_word;
    logic [BEAT_CW-1:0]  r_beat;
    logic [7:0]          r_drop_cnt;
    logic                r_valid;
    logic                r_last;
    logic [BEAT_CW-1:0]  w_beat_nxt;

    assign w_beat_nxt = r_beat + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_word     <= '0;
            r_beat     <= '0;
            r_drop_cnt <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_state <= S_SEND;
                        r_word  <= {i_b, i_a};
                        r_beat  <= '0;
                        r_valid <= 1'b1;
                        r_last  <= (BEATS == 1);
                    end
                end
                S_SEND: begin
                    if (i_valid && r_drop_cnt != 8'hFF) begin
                        r_drop_cnt <= r_drop_cnt + 8'd1;
                    end
                    if (i_ready) begin
                        if (r_beat == LAST_BEAT) begin
                            // Clear the word so o_data reads zero while idle.
                            r_state <= S_IDLE;
                            r_word  <= '0;
                            r_beat  <= '0;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                        end else begin
                            r_word <= r_word >> BEAT_W;
                            r_beat <= w_beat_nxt;
                            r_last <= (w_beat_nxt == LAST_BEAT);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_ready    = (r_state == S_IDLE);
    assign o_valid    = r_valid;
    assign o_last     = r_last;
    assign o_data     = r_word[BEAT_W-1:0];
    assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_lane_pack_serializer.sv
// Bench for lane_pack_serializer: queue-based frame model compared every cycle,
// directed frames with literal beat expectations, and a single-beat variant.
module tb_lane_pack_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_valid = 1'b0;
    logic [7:0] i_a = '0;
    logic [7:0] i_b = '0;
    logic       i_ready = 1'b1;
    logic       o_ready, o_valid, o_last;
    logic [3:0] o_data;
    logic [7:0] o_drop_cnt;

    logic        p_valid = 1'b0;
    logic [7:0]  p_a = '0;
    logic [7:0]  p_b = '0;
    logic        p_ready = 1'b1;
    logic        p_o_ready, p_o_valid, p_o_last;
    logic [15:0] p_o_data;
    logic [7:0]  p_drop_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lane_pack_serializer #(.LANES(8), .BEAT_W(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_a(i_a), .i_b(i_b),
        .o_ready(o_ready), .o_valid(o_valid), .o_data(o_data), .o_last(o_last),
        .i_ready(i_ready), .o_drop_cnt(o_drop_cnt)
    );

    lane_pack_serializer #(.LANES(8), .BEAT_W(16)) dut_wide (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(p_valid), .i_a(p_a), .i_b(p_b),
        .o_ready(p_o_ready), .o_valid(p_o_valid), .o_data(p_o_data), .o_last(p_o_last),
        .i_ready(p_ready), .o_drop_cnt(p_drop_cnt)
    );

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a frame is a list of pending beats; busy while any remain.
    logic [3:0] m_beats[$];
    int         m_drops = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_beats.delete();
                m_drops = 0;
            end else if (m_beats.size() == 0) begin
                if (i_valid) begin
                    logic [15:0] w;
                    w = {i_b, i_a};
                    for (int k = 0; k < 4; k++) m_beats.push_back(w[4*k +: 4]);
                end
            end else begin
                if (i_valid && m_drops < 255) m_drops++;
                if (i_ready) void'(m_beats.pop_front());
            end
        end
    end

    // Per-cycle compare plus a handshake recorder for the directed tests.
    logic [4:0] got[$];
    int n_valid = 0, n_notready = 0;
    int p_caps = 0, p_beats = 0, p_bad = 0;

    always @(negedge clk) begin
        logic busy;
        busy = (m_beats.size() != 0);
        chk("o_ready", 32'(o_ready), 32'(!busy));
        chk("o_valid", 32'(o_valid), 32'(busy));
        chk("o_data", 32'(o_data), busy ? 32'(m_beats[0]) : 32'd0);
        chk("o_last", 32'(o_last), 32'(busy && m_beats.size() == 1));
        chk("o_drop_cnt", 32'(o_drop_cnt), 32'(m_drops));
        if (rst_n) begin
            if (o_valid) n_valid++;
            if (!o_ready) n_notready++;
            if (o_valid && i_ready) got.push_back({o_last, o_data});
            if (p_valid && p_o_ready) p_caps++;
            if (p_o_valid && p_ready) begin
                p_beats++;
                if (p_o_data != 16'h1234 || !p_o_last) p_bad++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_rec();
        got.delete();
        n_valid = 0;
        n_notready = 0;
    endtask

    function automatic int unsigned pack_got();
        int unsigned v = 0;
        foreach (got[k]) v = (v << 5) | 32'(got[k]);
        return v;
    endfunction

    // Expected {last,data} sequence 5,A,C,3(last) packed 5 bits per beat.
    localparam int unsigned EXP_A53C = (32'h05 << 15) | (32'h0A << 10) | (32'h0C << 5) | 32'h13;
    localparam int unsigned EXP_1000 = (32'h01 << 15) | 32'h10;

    initial begin
        repeat (2) cyc();
        chk("reset_ready", 32'(o_ready), 32'd1);
        chk("reset_valid", 32'(o_valid), 32'd0);
        rst_n = 1'b1;
        cyc();

        // Basic frame
        clear_rec();
        i_a = 8'hA5; i_b = 8'h3C; i_ready = 1'b1; i_valid = 1'b1;
        cyc();
        i_valid = 1'b0;
        repeat (8) cyc();
        chk("basic_beats", pack_got(), EXP_A53C);
        chk("basic_notready", 32'(n_notready), 32'd4);
        chk("basic_valid_cycles", 32'(n_valid), 32'd4);

        // Backpressure during beat 1
        clear_rec();
        i_valid = 1'b1;
        cyc();
        i_valid = 1'b0;
        cyc();
        i_ready = 1'b0;
        repeat (3) cyc();
        i_ready = 1'b1;
        repeat (6) cyc();
        chk("bp_beats", pack_got(), EXP_A53C);
        chk("bp_valid_cycles", 32'(n_valid), 32'd7);

        // Drops during SEND
        clear_rec();
        i_valid = 1'b1;
        cyc();
        i_a = 8'hFF;
        repeat (2) cyc();
        i_valid = 1'b0;
        repeat (4) cyc();
        chk("drop_beats", pack_got(), EXP_A53C);
        chk("drop_cnt2", 32'(o_drop_cnt), 32'd2);

        // Reset mid-frame after beat 1 accepted
        i_a = 8'hA5; i_valid = 1'b1;
        cyc();
        i_valid = 1'b0;
        repeat (2) cyc();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_last", 32'(o_last), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_drop", 32'(o_drop_cnt), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        cyc();
        rst_n = 1'b1;
        cyc();
        clear_rec();
        i_a = 8'h01; i_b = 8'h00; i_valid = 1'b1;
        cyc();
        i_valid = 1'b0;
        repeat (6) cyc();
        chk("post_rst_beats", pack_got(), EXP_1000);

        // Single-beat variant, valid held high
        p_a = 8'h34; p_b = 8'h12; p_ready = 1'b1; p_valid = 1'b1;
        repeat (6) cyc();
        p_valid = 1'b0;
        repeat (3) cyc();
        chk("wide_captures", 32'(p_caps), 32'd3);
        chk("wide_beats", 32'(p_beats), 32'd3);
        chk("wide_bad_beats", 32'(p_bad), 32'd0);
        chk("wide_drops", 32'(p_drop_cnt), 32'd3);

        // Randomised traffic
        for (int n = 0; n < 2000; n++) begin
            i_valid = ($urandom_range(0, 9) < 3);
            i_ready = ($urandom_range(0, 9) < 7);
            i_a = 8'($urandom);
            i_b = 8'($urandom);
            cyc();
        end

        // Saturation
        i_valid = 1'b0; i_ready = 1'b1;
        repeat (10) cyc();
        i_valid = 1'b1;
        cyc();
        i_ready = 1'b0;
        repeat (300) cyc();
        chk("sat_255", 32'(o_drop_cnt), 32'd255);
        i_ready = 1'b1; i_valid = 1'b0;
        repeat (6) cyc();
        chk("sat_hold", 32'(o_drop_cnt), 32'd255);
        chk("sat_idle", 32'(o_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lane_pack_serializer.md
Name: lane_pack_serializer

Overview:
- Downstream collector for the per-lane registered outputs of the replicated interface-consumer modules.
- Captures one frame of LANES a-bits and LANES b-bits when the upstream offers it.
- Packs each frame into a 2*LANES-bit word and streams it out LSB-first as BEAT_W-bit beats on a valid/ready handshake.
- Counts frames offered while busy.

Parameters:
- LANES, 8, number of replicated lanes (width of i_a, i_b).
- BEAT_W, 4, output beat width in bits. 2*LANES must be divisible by BEAT_W; elaboration-time assertion otherwise.
- BEATS, derived = 2*LANES/BEAT_W, beats per frame (4 at defaults).

Ports:
- i_clk  input  1  clock; all state updates on posedge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  upstream offers a frame this cycle.
- i_a  input  LANES  per-lane a bits.
- i_b  input  LANES  per-lane b bits.
- o_ready  output  1  block can accept a frame.
- o_valid  output  1  o_data holds a valid beat.
- o_data  output  BEAT_W  current beat.
- o_last  output  1  current beat is the final beat of the frame.
- i_ready  input  1  downstream accepts the beat.
- o_drop_cnt  output  8  saturating count of frames offered while busy.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE; word=0; beat=0.
  - o_valid=0, o_data=0, o_last=0, o_drop_cnt=0.
  - o_ready=1 once in IDLE.
- Packing: word = {i_b, i_a}, so i_a[0] is bit 0 and i_b[LANES-1] is bit 2*LANES-1.
- o_ready = (state==IDLE), combinational from state only; no dependence on i_valid or i_ready.
- IDLE:
  - i_valid && o_ready at posedge: capture word, beat=0, go to SEND.
  - Next cycle: o_valid=1, o_data=word[BEAT_W-1:0]. Capture-to-first-beat latency is 1 cycle.
- SEND:
  - o_valid=1 throughout.
  - o_data = word[BEAT_W-1:0] (word is shifted; no mux over beat index).
  - o_last = (beat==BEATS-1).
  - i_ready=0: o_data, o_last, word and beat are held stable (AXI-style: no retraction, no change while stalled).
  - i_ready=1 and beat<BEATS-1: word >>= BEAT_W, beat++.
  - i_ready=1 and beat==BEATS-1: go to IDLE. Next cycle o_valid=0, o_last=0, o_data=0.
- Throughput:
  - Frames cannot be captured in the last-handshake cycle.
  - With i_ready held high, the minimum frame period is BEATS+1 cycles.
- Drops:
  - i_valid=1 while state==SEND: frame is discarded.
  - o_drop_cnt increments by 1 and saturates at 255 (no wrap).
  - The in-flight frame is unaffected.
- Simultaneous events: i_valid during the final handshake cycle is still SEND, so it counts as a drop.
- Reset mid-frame: frame is lost. Outputs return to reset values asynchronously; no partial beat is emitted after release.
- Single-beat config (BEAT_W=2*LANES, BEATS=1): o_last=1 with the first and only beat; beat counter is width max(1, clog2(BEATS)).
- X-safety: i_a and i_b are sampled only on capture. o_data must never show X in IDLE.

Test Plan:
- Basic frame: reset, i_a=8'hA5, i_b=8'h3C, i_valid 1 cycle, i_ready=1 -> beats 4'h5, 4'hA, 4'hC, 4'h3 on 4 consecutive cycles starting 1 cycle after capture; o_last only on 4'h3; o_ready low for exactly 4 cycles.
- Backpressure: same frame, i_ready=0 for 3 cycles during beat 1 -> o_data stays 4'hA and o_valid stays 1 for those cycles; total 7 cycles of o_valid; beat order unchanged.
- Drops: during SEND assert i_valid on 2 cycles with i_a=8'hFF -> o_drop_cnt=2; output beats still 5,A,C,3; next frame accepted only after o_ready returns.
- Saturation: hold i_ready=0 in SEND and assert i_valid for 300 cycles -> o_drop_cnt reaches 255 and stays 255.
- Reset mid-frame: assert i_rst_n=0 after beat 1 is accepted -> o_valid, o_last, o_data go to 0 immediately, o_drop_cnt=0; after release o_ready=1; next frame i_a=8'h01, i_b=8'h00 -> beats 1,0,0,0.
- Param variant LANES=8, BEAT_W=16: i_a=8'h34, i_b=8'h12 -> one beat 16'h1234 with o_last=1; back-to-back frames with i_valid held high are captured every 2 cycles.
